sprite_painter: RTL and testbench
=================================

Name: sprite_painter

Overview:
- Parametrised image painter for the HDMI pipeline. It draws a ROM-stored image at a position and integer scale chosen at run time, over a background colour, with optional colour-key transparency.
- Sits between the display timing generator (sx, sy, de, frame_start) and the TMDS encoder, and drives an external synchronous ROM.
- All outputs are pipeline-aligned to a delayed de.

Parameters:
- IMG_WIDTH, 200, image width in source pixels.
- IMG_HEIGHT, 112, image height in source pixels.
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
- COORD_W, 11, width of sx, sy, pos_x and pos_y.
- BG_COLOR, 24'h113377, background RGB.
- KEY_EN, 1, 1 enables colour-key transparency.
- KEY_COLOR, 24'hFF00FF, ROM value treated as transparent.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  synchronous active-high reset.
- sx  in  COORD_W  horizontal screen position.
- sy  in  COORD_W  vertical screen position.
- de  in  1  data enable (active area).
- frame_start  in  1  one-cycle pulse at the first active pixel of a frame.
- pos_x  in  COORD_W  requested image left edge.
- pos_y  in  COORD_W  requested image top edge.
- scale  in  2  scale exponent; the image is drawn at 2^scale times (1, 2, 4 or 8).
- rom_addr  out  ADDR_W  ROM address.
- rom_en  out  1  ROM read enable.
- rom_dout  in  24  ROM data, valid exactly one cycle after rom_addr/rom_en.
- rgb_r  out  8  red.
- rgb_g  out  8  green.
- rgb_b  out  8  blue.
- de_out  out  1  de delayed to align with rgb.

Behaviour:
- Reset: all of the following are 0 at the first edge with rst_pix high:
  - rom_addr, rom_en, rgb_r, rgb_g, rgb_b, de_out;
  - all pipeline flags;
  - the latched px, py and sc.
- A mid-frame reset discards pipeline contents. Drawing resumes correctly from the next frame_start.
- Parameter latch: px, py and sc capture pos_x, pos_y and scale on any cycle with frame_start=1. They are stable for the rest of the frame. Changes to the inputs between pulses have no effect.
- Extent: DW = IMG_WIDTH<<sc and DH = IMG_HEIGHT<<sc.
  - Compute the extent and the comparisons at COORD_W+4 bits so that px+DW never wraps.
  - An image partly off-screen is clipped.
  - An image fully off-screen draws only background.
- in_rect = de and (px <= sx < px+DW) and (py <= sy < py+DH).
- Stage 1, registered at edge N+1 for input cycle N:
  - rom_en = in_rect.
  - rom_addr = ((sy-py)>>sc)*IMG_WIDTH + ((sx-px)>>sc) when in_rect. Otherwise rom_addr holds its previous value.
  - Delay in_rect and de by one stage.
- Address generation is counter-based, with no multiplier:
  - Counter state: x sub-counter, y sub-counter, column index, row base.
  - The row base advances by IMG_WIDTH once every 2^sc image lines.
  - The column index resets at the left edge and increments once every 2^sc pixels.
  - Input is assumed to be raster order, as produced by the timing generator. Counters reinitialise on frame_start and on each row's left-edge hit.
  - The resulting rom_addr must equal the formula above for every in_rect pixel.
- Stage 2: ROM data arrives during cycle N+2. Delay in_rect and de a second time.
- Stage 3, registered at edge N+3:
  - de_out = de delayed by 3 cycles.
  - If de_d2=0, rgb = 0.
  - Else if in_rect_d2=1 and not (KEY_EN and rom_dout==KEY_COLOR), rgb = rom_dout.
  - Otherwise rgb = BG_COLOR.
- Fixed latency: exactly 3 cycles from (sx, sy, de) to (rgb, de_out), for every pixel and every scale.
- The last source pixel maps to address IMG_WIDTH*IMG_HEIGHT-1. Address never exceeds this value.
- frame_start coinciding with an in_rect pixel uses the newly latched values for that same pixel. The latch is transparent in stage 1 for that cycle.

Test Plan:
- Reset: assert rst_pix for 4 cycles with de=1 toggling -> rgb=0, de_out=0, rom_en=0 throughout, and 1 cycle after release.
- Scale 0: pos=(540,304) latched on frame_start.
  - Pixel (540,304) -> rom_addr=0 at N+1; rgb=ROM[0] at N+3.
  - Pixel (739,415) -> rom_addr=22399.
  - Pixel (740,304) -> BG 113377.
- Scale 2: pos=(100,50).
  - Pixels (100..103, 50..53) -> all rom_addr=0.
  - Pixel (104,50) -> 1.
  - Pixel (100,54) -> 200.
  - Pixel (899,497) -> 22399.
  - Pixel (900,50) -> background.
- Colour key: ROM word 5 = FF00FF with KEY_EN=1 -> that pixel outputs 113377 while neighbours output ROM data. With KEY_EN=0 -> FF00FF.
- Clipping and latch: pos=(1200,700) at scale 1 -> only the on-screen top-left region is drawn, with no address wrap.
  - Change pos_x mid-frame -> no effect until the next frame_start.
- Blanking and mid-frame reset: de=0 inside the rect -> rgb=0, rom_en=0.
  - Reset pulse mid-row -> outputs 0. The next frame matches the scale-0 golden image pixel-for-pixel.

Source files
------------

// File: rtl/sprite_painter.sv
// rtl/sprite_painter.sv - scaled ROM image painter with colour key, 3-cycle pipeline
module sprite_painter #(
  parameter int          IMG_WIDTH  = 200,
  parameter int          IMG_HEIGHT = 112,
  parameter int          ADDR_W     = 15,
  parameter int          COORD_W    = 11,
  parameter logic [23:0] BG_COLOR   = 24'h113377,
  parameter int          KEY_EN     = 1,
  parameter logic [23:0] KEY_COLOR  = 24'hFF00FF
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic [COORD_W-1:0] sx,
  input  logic [COORD_W-1:0] sy,
  input  logic               de,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [1:0]         scale,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_en,
  input  logic [23:0]        rom_dout,
  output logic [7:0]         rgb_r,
  output logic [7:0]         rgb_g,
  output logic [7:0]         rgb_b,
  output logic               de_out
);

  localparam int W = COORD_W + 4;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_WIDTH);

  logic [COORD_W-1:0] px, py, px_e, py_e;
  logic [1:0]         sc, sc_e;

  // frame_start makes the new placement visible to the pixel it arrives with
  assign px_e = frame_start ? pos_x : px;
  assign py_e = frame_start ? pos_y : py;
  assign sc_e = frame_start ? scale : sc;

  logic [W-1:0] sx_w, sy_w, px_w, py_w, dw, dh;
  assign sx_w = W'(sx);
  assign sy_w = W'(sy);
  assign px_w = W'(px_e);
  assign py_w = W'(py_e);
  assign dw   = W'(IMG_WIDTH) << sc_e;
  assign dh   = W'(IMG_HEIGHT) << sc_e;

  logic in_rect, left_hit;
  assign in_rect  = de && (sx_w >= px_w) && (sx_w < px_w + dw)
                       && (sy_w >= py_w) && (sy_w < py_w + dh);
  assign left_hit = in_rect && (sx == px_e);

  logic [2:0] sub_max;
  always_comb begin
    sub_max = 3'd0;
    case (sc_e)
      2'd0: sub_max = 3'd0;
      2'd1: sub_max = 3'd1;
      2'd2: sub_max = 3'd3;
      2'd3: sub_max = 3'd7;
      default: sub_max = 3'd0;
    endcase
  end

  // Counter state describes the next pixel expected in raster order
  logic [2:0]        xsub, ysub, cur_xsub, cur_ysub;
  logic [ADDR_W-1:0] col, row_base, cur_col, cur_rb, addr_next;
  logic              row_seen;

  always_comb begin
    cur_xsub = xsub;
    cur_ysub = ysub;
    cur_col  = col;
    cur_rb   = row_base;
    if (left_hit) begin
      cur_xsub = 3'd0;
      cur_col  = '0;
      if (frame_start || !row_seen) begin
        cur_ysub = 3'd0;
        cur_rb   = '0;
      end else if (ysub == sub_max) begin
        cur_ysub = 3'd0;
        cur_rb   = row_base + ROW_STEP;
      end else begin
        cur_ysub = ysub + 3'd1;
      end
    end
  end

  assign addr_next = cur_rb + cur_col;

  logic in_rect_d1, in_rect_d2, de_d1, de_d2;
  logic [23:0] pix;

  always_comb begin
    pix = BG_COLOR;
    if (!de_d2)
      pix = 24'h0;
    else if (in_rect_d2 && !((KEY_EN != 0) && (rom_dout == KEY_COLOR)))
      pix = rom_dout;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      px         <= '0;
      py         <= '0;
      sc         <= '0;
      xsub       <= '0;
      ysub       <= '0;
      col        <= '0;
      row_base   <= '0;
      row_seen   <= 1'b0;
      rom_addr   <= '0;
      rom_en     <= 1'b0;
      in_rect_d1 <= 1'b0;
      in_rect_d2 <= 1'b0;
      de_d1      <= 1'b0;
      de_d2      <= 1'b0;
      de_out     <= 1'b0;
      rgb_r      <= '0;
      rgb_g      <= '0;
      rgb_b      <= '0;
    end else begin
      if (frame_start) begin
        px <= pos_x;
        py <= pos_y;
        sc <= scale;
      end
      if (left_hit)
        row_seen <= 1'b1;
      else if (frame_start)
        row_seen <= 1'b0;
      if (in_rect) begin
        ysub     <= cur_ysub;
        row_base <= cur_rb;
        if (cur_xsub == sub_max) begin
          xsub <= 3'd0;
          col  <= cur_col + ADDR_W'(1);
        end else begin
          xsub <= cur_xsub + 3'd1;
          col  <= cur_col;
        end
        rom_addr <= addr_next;
      end
      rom_en     <= in_rect;
      in_rect_d1 <= in_rect;
      de_d1      <= de;
      in_rect_d2 <= in_rect_d1;
      de_d2      <= de_d1;
      de_out     <= de_d2;
      rgb_r      <= pix[23:16];
      rgb_g      <= pix[15:8];
      rgb_b      <= pix[7:0];
    end
  end

endmodule

// File: tb/tb_sprite_painter.sv
// tb/tb_sprite_painter.sv - directed raster-scan bench for sprite_painter
module tb_sprite_painter;

  localparam logic [23:0] BG  = 24'h113377;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        clk_pix = 1'b0;
  logic        rst_pix = 1'b1;
  logic [10:0] sx = '0, sy = '0, pos_x = '0, pos_y = '0;
  logic        de = 1'b0, frame_start = 1'b0;
  logic [1:0]  scale = '0;

  logic [14:0] rom_addr, rom_addr_nk;
  logic        rom_en, rom_en_nk, de_out, de_out_nk;
  logic [23:0] rom_q, rom_q_nk;
  logic [7:0]  r, g, b, r_nk, g_nk, b_nk;

  always #5 clk_pix = ~clk_pix;

  sprite_painter u_dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .scale(scale),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_dout(rom_q),
    .rgb_r(r), .rgb_g(g), .rgb_b(b), .de_out(de_out)
  );

  sprite_painter #(.KEY_EN(0)) u_dut_nk (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .scale(scale),
    .rom_addr(rom_addr_nk), .rom_en(rom_en_nk), .rom_dout(rom_q_nk),
    .rgb_r(r_nk), .rgb_g(g_nk), .rgb_b(b_nk), .de_out(de_out_nk)
  );

  // Word 5 holds the key colour; every other word has bit 23 clear
  function automatic logic [23:0] rom_word(input logic [14:0] a);
    return (a == 15'd5) ? KEY : {1'b0, a, 8'hA5};
  endfunction

  always_ff @(posedge clk_pix) begin
    if (rom_en)    rom_q    <= rom_word(rom_addr);
    if (rom_en_nk) rom_q_nk <= rom_word(rom_addr_nk);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        vld;
    logic        de;
    logic [23:0] rgb;
    logic [23:0] nk;
    logic [11:0] x;
    logic [11:0] y;
  } stage_t;

  stage_t p1 = '0, p2 = '0, p3 = '0;
  int     mpx = 0, mpy = 0, msc = 0, m_addr = 0;
  logic   m_en = 1'b0;

  logic [23:0] rgb_obs [int];
  logic [23:0] nk_obs [int];
  int          addr_obs [int];
  logic        en_obs [int];

  function automatic int k(input int x, input int y);
    return y * 4096 + x;
  endfunction

  task automatic cyc(input int x, input int y, input logic d, input logic fs);
    stage_t n;
    logic   inr;
    int     lpx, lpy, lsc, ea;
    sx = 11'(x); sy = 11'(y); de = d; frame_start = fs;
    lpx = fs ? int'(pos_x) : mpx;
    lpy = fs ? int'(pos_y) : mpy;
    lsc = fs ? int'(scale) : msc;
    inr = d && x >= lpx && x < lpx + (200 << lsc) && y >= lpy && y < lpy + (112 << lsc);
    ea  = inr ? ((y - lpy) >> lsc) * 200 + ((x - lpx) >> lsc) : 0;
    n.vld = 1'b1;
    n.de  = d;
    n.x   = 12'(x);
    n.y   = 12'(y);
    if (!d) begin
      n.rgb = 24'h0;
      n.nk  = 24'h0;
    end else if (inr) begin
      n.nk  = rom_word(15'(ea));
      n.rgb = (n.nk == KEY) ? BG : n.nk;
    end else begin
      n.rgb = BG;
      n.nk  = BG;
    end
    @(posedge clk_pix);
    if (rst_pix) begin
      mpx = 0; mpy = 0; msc = 0; m_addr = 0; m_en = 1'b0;
      p1 = '0; p2 = '0; p3 = '0;
    end else begin
      if (fs) begin mpx = lpx; mpy = lpy; msc = lsc; end
      m_en = inr;
      if (inr) m_addr = ea;
      p3 = p2; p2 = p1; p1 = n;
    end
    #1;
    check("rom_en", rom_en, m_en);
    check("rom_addr", rom_addr, m_addr);
    check("de_out", de_out, p3.de);
    check("rgb", {r, g, b}, p3.rgb);
    check("rgb_nokey", {r_nk, g_nk, b_nk}, p3.nk);
    if (!rst_pix) begin
      en_obs[k(x, y)] = rom_en;
      if (rom_en) addr_obs[k(x, y)] = int'(rom_addr);
    end
    if (p3.vld) begin
      rgb_obs[k(int'(p3.x), int'(p3.y))] = {r, g, b};
      nk_obs[k(int'(p3.x), int'(p3.y))]  = {r_nk, g_nk, b_nk};
    end
  endtask

  task automatic row(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) cyc(x, y, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2047, 2047, 1'b0, 1'b0);
  endtask

  task automatic new_frame(input int x, input int y, input int s);
    pos_x = 11'(x); pos_y = 11'(y); scale = 2'(s);
    cyc(0, 0, 1'b1, 1'b1);
  endtask

  initial begin
    // Reset with de toggling over an in-image position
    rst_pix = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1'(i % 2), 1'b0);
      check("rst_rgb", {r, g, b}, 24'h0);
      check("rst_de_out", de_out, 1'b0);
      check("rst_rom_en", rom_en, 1'b0);
    end
    rst_pix = 1'b0;
    cyc(2047, 2047, 1'b0, 1'b0);
    check("post_rst_rgb", {r, g, b}, 24'h0);
    check("post_rst_rom_en", rom_en, 1'b0);
    check("post_rst_addr", rom_addr, 15'd0);

    // Scale 0 at (540,304)
    new_frame(540, 304, 0);
    for (int y = 304; y <= 415; y++) begin
      if (y == 304 || y == 415) row(y, 538, 742);
      else cyc(540, y, 1'b1, 1'b0);
    end
    idle(4);
    check("s0_first_addr", addr_obs[k(540, 304)], 0);
    check("s0_first_rgb", rgb_obs[k(540, 304)], 24'h0000A5);
    check("s0_last_addr", addr_obs[k(739, 415)], 22399);
    check("s0_last_rgb", rgb_obs[k(739, 415)], 24'h577FA5);
    check("s0_right_bg", rgb_obs[k(740, 304)], BG);
    check("s0_left_bg", rgb_obs[k(539, 304)], BG);
    check("key_pixel", rgb_obs[k(545, 304)], BG);
    check("key_left", rgb_obs[k(544, 304)], 24'h0004A5);
    check("key_right", rgb_obs[k(546, 304)], 24'h0006A5);
    check("nokey_pixel", nk_obs[k(545, 304)], KEY);

    // Scale 2 at (100,50)
    new_frame(100, 50, 2);
    for (int y = 50; y <= 497; y++) begin
      if (y == 50 || y == 497) row(y, 98, 901);
      else if (y <= 53) row(y, 100, 105);
      else if (y == 54) row(y, 100, 104);
      else cyc(100, y, 1'b1, 1'b0);
    end
    idle(4);
    for (int y = 50; y <= 53; y++)
      for (int x = 100; x <= 103; x++)
        check("s2_block0", addr_obs[k(x, y)], 0);
    check("s2_col1", addr_obs[k(104, 50)], 1);
    check("s2_row1", addr_obs[k(100, 54)], 200);
    check("s2_last", addr_obs[k(899, 497)], 22399);
    check("s2_right_bg", rgb_obs[k(900, 50)], BG);

    // Clipped at (1200,700) scale 1; pos moved mid-frame must be ignored
    new_frame(1200, 700, 1);
    pos_x = 11'd0; pos_y = 11'd0; scale = 2'd0;
    cyc(5, 700, 1'b1, 1'b0);
    row(700, 1195, 1279);
    for (int y = 701; y <= 719; y++) row(y, 1198, 1279);
    idle(4);
    check("clip_first", addr_obs[k(1200, 700)], 0);
    check("clip_sub", addr_obs[k(1201, 701)], 0);
    check("clip_step", addr_obs[k(1202, 702)], 201);
    check("clip_corner", addr_obs[k(1279, 719)], 1839);
    check("clip_corner_rgb", rgb_obs[k(1279, 719)], 24'h072FA5);
    check("clip_left_bg", rgb_obs[k(1199, 700)], BG);
    check("latch_hold", rgb_obs[k(5, 700)], BG);

    // New placement on the frame_start pixel itself, then blanking inside the image
    new_frame(0, 0, 0);
    row(0, 1, 9);
    cyc(10, 0, 1'b0, 1'b0);
    row(1, 0, 3);
    idle(4);
    check("fs_same_pixel_en", en_obs[k(0, 0)], 1'b1);
    check("fs_same_pixel_addr", addr_obs[k(0, 0)], 0);
    check("fs_same_pixel_rgb", rgb_obs[k(0, 0)], 24'h0000A5);
    check("blank_rgb", rgb_obs[k(10, 0)], 24'h0);
    check("blank_en", en_obs[k(10, 0)], 1'b0);
    check("blank_next_row", addr_obs[k(2, 1)], 202);

    // Mid-row reset, then a full golden frame
    new_frame(540, 304, 0);
    row(304, 538, 742);
    row(305, 538, 600);
    rst_pix = 1'b1;
    cyc(601, 305, 1'b1, 1'b0);
    rst_pix = 1'b0;
    check("midrst_rgb", {r, g, b}, 24'h0);
    check("midrst_de_out", de_out, 1'b0);
    check("midrst_rom_en", rom_en, 1'b0);
    row(305, 602, 700);
    idle(4);
    addr_obs.delete();
    rgb_obs.delete();
    new_frame(540, 304, 0);
    for (int y = 304; y <= 415; y++) row(y, 538, 742);
    idle(4);
    check("golden_first", rgb_obs[k(540, 304)], 24'h0000A5);
    check("golden_last_addr", addr_obs[k(739, 415)], 22399);
    check("golden_last_rgb", rgb_obs[k(739, 415)], 24'h577FA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
